obi_wrr_arbiter: RTL and testbench

Weighted round-robin arbiter that shares one OBI subordinate port among `NumReq` OBI managers. Each address-phase grant is tracked in an in-order outstanding FIFO, so responses return to the manager that issued them. It sits in front of a single shared subordinate, such as a memory bank or peripheral port, where a full crossbar is unnecessary. Per-requester weights are runtime inputs.

---
 rtl/obi_wrr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_obi_wrr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_wrr_arbiter.sv
// Weighted round-robin arbiter: NumReq OBI managers share one OBI subordinate port.
// An in-order FIFO of granted indices steers each response back to its issuer.
module obi_wrr_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned IdWidth     = 5,
    parameter int unsigned NumMaxTrans = 4,
    parameter int unsigned WeightWidth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [WeightWidth-1:0] weight_i     [NumReq],
    // manager-facing side (one per requester)
    input  logic                   sbr_req_i    [NumReq],
    output logic                   sbr_gnt_o    [NumReq],
    input  logic [AddrWidth-1:0]   sbr_addr_i   [NumReq],
    input  logic                   sbr_we_i     [NumReq],
    input  logic [DataWidth/8-1:0] sbr_be_i     [NumReq],
    input  logic [DataWidth-1:0]   sbr_wdata_i  [NumReq],
    input  logic [IdWidth-1:0]     sbr_aid_i    [NumReq],
    output logic                   sbr_rvalid_o [NumReq],
    input  logic                   sbr_rready_i [NumReq],
    output logic [DataWidth-1:0]   sbr_rdata_o  [NumReq],
    output logic [IdWidth-1:0]     sbr_rid_o    [NumReq],
    output logic                   sbr_err_o    [NumReq],
    // shared subordinate side
    output logic                   mgr_req_o,
    input  logic                   mgr_gnt_i,
    output logic [AddrWidth-1:0]   mgr_addr_o,
    output logic                   mgr_we_o,
    output logic [DataWidth/8-1:0] mgr_be_o,
    output logic [DataWidth-1:0]   mgr_wdata_o,
    output logic [IdWidth-1:0]     mgr_aid_o,
    input  logic                   mgr_rvalid_i,
    output logic                   mgr_rready_o,
    input  logic [DataWidth-1:0]   mgr_rdata_i,
    input  logic [IdWidth-1:0]     mgr_rid_i,
    input  logic                   mgr_err_i,
    output logic                   busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    logic [IdxW-1:0]        prio_q, prio_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic                   lock_q, lock_d;
    logic [IdxW-1:0]        lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]        fifo_q [NumMaxTrans];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;

    logic [IdxW-1:0] sel, next_sel, head;
    logic [IdxW:0]   cand;
    logic            found, full, empty, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(NumMaxTrans - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full  = (cnt_q == CntW'(NumMaxTrans));
    assign empty = (cnt_q == '0);

    // Cyclic search from the priority pointer; a pending lock overrides it.
    always_comb begin
        sel   = prio_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = {1'b0, prio_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (!found && sbr_req_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IdxW-1:0];
            end
        end
        if (lock_q) begin
            sel = lock_idx_q;
        end
    end

    assign next_sel = (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);

    assign mgr_req_o   = sbr_req_i[sel] & ~full;
    assign mgr_addr_o  = sbr_addr_i[sel];
    assign mgr_we_o    = sbr_we_i[sel];
    assign mgr_be_o    = sbr_be_i[sel];
    assign mgr_wdata_o = sbr_wdata_i[sel];
    assign mgr_aid_o   = sbr_aid_i[sel];
    assign push        = mgr_req_o & mgr_gnt_i;

    assign head         = fifo_q[rd_ptr_q];
    assign mgr_rready_o = sbr_rready_i[head] & ~empty;
    assign pop          = mgr_rvalid_i & mgr_rready_o;
    assign busy_o       = ~empty | mgr_req_o;

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            sbr_gnt_o[i]    = push && (sel == IdxW'(i));
            sbr_rvalid_o[i] = mgr_rvalid_i && !empty && (head == IdxW'(i));
            sbr_rdata_o[i]  = mgr_rdata_i;
            sbr_rid_o[i]    = mgr_rid_i;
            sbr_err_o[i]    = mgr_err_i;
        end
    end

    // A turn opens by loading the requester's weight as bonus grants; the pointer
    // moves on once the bonuses are spent, so each requester gets weight+1 in a row.
    always_comb begin
        prio_d     = prio_q;
        credit_d   = credit_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (mgr_req_o && !mgr_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        if (push) begin
            lock_d = 1'b0;
            if (sel == prio_q && credit_q != '0) begin
                credit_d = credit_q - WeightWidth'(1);
                if (credit_q == WeightWidth'(1)) begin
                    prio_d = next_sel;
                end
            end else if (weight_i[sel] == '0) begin
                prio_d   = next_sel;
                credit_d = '0;
            end else begin
                prio_d   = sel;
                credit_d = weight_i[sel];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= '0;
            credit_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            prio_q     <= prio_d;
            credit_q   <= credit_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    // A response with nothing outstanding has no owner; it is dropped.
    assert property (@(posedge clk_i) disable iff (rst_i) !(mgr_rvalid_i && empty));

endmodule

// File: tb/tb_obi_wrr_arbiter.sv
// Directed self-checking bench for obi_wrr_arbiter: lock, weighting, full stall,
// response routing, mid-flight reset and simultaneous push/pop.
module tb_obi_wrr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int NT = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [WW-1:0]   weight     [NR];
    logic            sbr_req    [NR];
    logic            sbr_gnt    [NR];
    logic [AW-1:0]   sbr_addr   [NR];
    logic            sbr_we     [NR];
    logic [DW/8-1:0] sbr_be     [NR];
    logic [DW-1:0]   sbr_wdata  [NR];
    logic [IW-1:0]   sbr_aid    [NR];
    logic            sbr_rvalid [NR];
    logic            sbr_rready [NR];
    logic [DW-1:0]   sbr_rdata  [NR];
    logic [IW-1:0]   sbr_rid    [NR];
    logic            sbr_err    [NR];
    logic            mgr_req, mgr_gnt, mgr_we, mgr_rvalid, mgr_rready, mgr_err, busy;
    logic [AW-1:0]   mgr_addr;
    logic [DW/8-1:0] mgr_be;
    logic [DW-1:0]   mgr_wdata, mgr_rdata;
    logic [IW-1:0]   mgr_aid, mgr_rid;

    int checks = 0;
    int fails  = 0;

    obi_wrr_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
        .NumMaxTrans(NT), .WeightWidth(WW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .weight_i(weight),
        .sbr_req_i(sbr_req), .sbr_gnt_o(sbr_gnt), .sbr_addr_i(sbr_addr), .sbr_we_i(sbr_we),
        .sbr_be_i(sbr_be), .sbr_wdata_i(sbr_wdata), .sbr_aid_i(sbr_aid),
        .sbr_rvalid_o(sbr_rvalid), .sbr_rready_i(sbr_rready), .sbr_rdata_o(sbr_rdata),
        .sbr_rid_o(sbr_rid), .sbr_err_o(sbr_err),
        .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
        .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata), .mgr_aid_o(mgr_aid),
        .mgr_rvalid_i(mgr_rvalid), .mgr_rready_o(mgr_rready), .mgr_rdata_i(mgr_rdata),
        .mgr_rid_i(mgr_rid), .mgr_err_i(mgr_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NR; k++) begin
            weight[k]     = '0;
            sbr_req[k]    = 1'b0;
            sbr_rready[k] = 1'b1;
        end
        mgr_gnt    = 1'b0;
        mgr_rvalid = 1'b0;
        mgr_rdata  = '0;
        mgr_rid    = '0;
        mgr_err    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Index of the single granted requester, -1 for none, -2 for several.
    function automatic int gnt_idx();
        int r = -1;
        for (int k = 0; k < NR; k++) begin
            if (sbr_gnt[k] === 1'b1) r = (r == -1) ? k : -2;
        end
        return r;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (mgr_req !== 1'b0) begin
            fails++; $display("FAIL reset_mgr_req: got %b expected 0", mgr_req);
        end
        checks++;
        if (mgr_rready !== 1'b0) begin
            fails++; $display("FAIL reset_mgr_rready: got %b expected 0", mgr_rready);
        end
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (sbr_gnt[k] !== 1'b0 || sbr_rvalid[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_sbr[%0d]: got gnt=%b rvalid=%b expected 0/0",
                         k, sbr_gnt[k], sbr_rvalid[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        sbr_req[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) sbr_req[1] = 1'b1;
            mgr_gnt = (c == 3);
            #1;
            checks++;
            if (mgr_req !== 1'b1 || mgr_addr !== sbr_addr[0]) begin
                fails++;
                $display("FAIL lock_addr c%0d: got req=%b addr=%h expected 1/%h",
                         c, mgr_req, mgr_addr, sbr_addr[0]);
            end
            checks++;
            if (sbr_gnt[0] !== (c == 3) || sbr_gnt[1] !== 1'b0) begin
                fails++;
                $display("FAIL lock_gnt c%0d: got gnt0=%b gnt1=%b expected %b/0",
                         c, sbr_gnt[0], sbr_gnt[1], (c == 3));
            end
            step();
        end
        sbr_req[0] = 1'b0;
        #1;
        checks++;
        if (sbr_gnt[1] !== 1'b1 || mgr_addr !== sbr_addr[1]) begin
            fails++;
            $display("FAIL lock_after: got gnt1=%b addr=%h expected 1/%h",
                     sbr_gnt[1], mgr_addr, sbr_addr[1]);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_weighted();
        int exp_pat [7];
        int cnt [NR];
        int prev;
        int g;
        exp_pat[0] = 0; exp_pat[1] = 0; exp_pat[2] = 0; exp_pat[3] = 1;
        exp_pat[4] = 2; exp_pat[5] = 2; exp_pat[6] = 3;
        do_reset();
        weight[0] = 4'd2; weight[1] = 4'd0; weight[2] = 4'd1; weight[3] = 4'd0;
        for (int k = 0; k < NR; k++) begin
            sbr_req[k] = 1'b1;
            cnt[k]     = 0;
        end
        mgr_gnt = 1'b1;
        prev    = -1;
        for (int n = 0; n < 700; n++) begin
            mgr_rvalid = (prev >= 0);
            mgr_rdata  = DW'(n);
            #1;
            g = gnt_idx();
            checks++;
            if (g != exp_pat[n % 7]) begin
                fails++; $display("FAIL wrr_order n%0d: got %0d expected %0d", n, g, exp_pat[n % 7]);
            end
            if (prev >= 0) begin
                checks++;
                if (sbr_rvalid[prev] !== 1'b1 || mgr_rready !== 1'b1) begin
                    fails++;
                    $display("FAIL wrr_resp n%0d: got rvalid=%b rready=%b expected 1/1",
                             n, sbr_rvalid[prev], mgr_rready);
                end
            end
            if (g >= 0) cnt[g]++;
            prev = g;
            step();
        end
        checks++;
        if (cnt[0] != 300 || cnt[1] != 100 || cnt[2] != 200 || cnt[3] != 100) begin
            fails++;
            $display("FAIL wrr_counts: got %0d/%0d/%0d/%0d expected 300/100/200/100",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        idle_inputs();
    endtask

    task automatic test_full_stall();
        int grants = 0;
        do_reset();
        sbr_req[2] = 1'b1;
        mgr_gnt    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (mgr_req !== (c < NT)) begin
                fails++; $display("FAIL full_req c%0d: got %b expected %b", c, mgr_req, (c < NT));
            end
            if (sbr_gnt[2] === 1'b1) grants++;
            step();
        end
        checks++;
        if (grants != NT) begin
            fails++; $display("FAIL full_grants: got %0d expected %0d", grants, NT);
        end
        mgr_rvalid = 1'b1;
        #1;
        checks++;
        if (mgr_req !== 1'b0 || sbr_rvalid[2] !== 1'b1 || mgr_rready !== 1'b1) begin
            fails++;
            $display("FAIL full_pop_cycle: got req=%b rvalid=%b rready=%b expected 0/1/1",
                     mgr_req, sbr_rvalid[2], mgr_rready);
        end
        step();
        mgr_rvalid = 1'b0;
        #1;
        checks++;
        if (mgr_req !== 1'b1) begin
            fails++; $display("FAIL full_unblock: got %b expected 1", mgr_req);
        end
        idle_inputs();
    endtask

    task automatic test_routing();
        int order [3];
        logic [DW-1:0] rd [3];
        order[0] = 2; order[1] = 0; order[2] = 3;
        rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
        do_reset();
        mgr_gnt = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < NR; k++) sbr_req[k] = (k == order[t]);
            #1;
            checks++;
            if (gnt_idx() != order[t]) begin
                fails++; $display("FAIL route_gnt t%0d: got %0d expected %0d", t, gnt_idx(), order[t]);
            end
            step();
        end
        idle_inputs();
        mgr_rvalid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            mgr_rdata = rd[t];
            if (t == 1) begin
                sbr_rready[0] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    #1;
                    checks++;
                    if (mgr_rready !== 1'b0 || sbr_rvalid[0] !== 1'b1 || sbr_rvalid[3] !== 1'b0) begin
                        fails++;
                        $display("FAIL route_stall c%0d: got rready=%b rv0=%b rv3=%b expected 0/1/0",
                                 c, mgr_rready, sbr_rvalid[0], sbr_rvalid[3]);
                    end
                    step();
                end
                sbr_rready[0] = 1'b1;
            end
            #1;
            checks++;
            if (sbr_rvalid[order[t]] !== 1'b1 || sbr_rdata[order[t]] !== rd[t]
                || mgr_rready !== 1'b1) begin
                fails++;
                $display("FAIL route_resp t%0d: got rvalid=%b rdata=%h rready=%b expected 1/%h/1",
                         t, sbr_rvalid[order[t]], sbr_rdata[order[t]], mgr_rready, rd[t]);
            end
            for (int k = 0; k < NR; k++) begin
                if (k != order[t]) begin
                    checks++;
                    if (sbr_rvalid[k] !== 1'b0) begin
                        fails++; $display("FAIL route_other t%0d k%0d: got %b expected 0", t, k, sbr_rvalid[k]);
                    end
                end
            end
            step();
        end
        mgr_rvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL route_drained: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sbr_req[0] = 1'b1; sbr_req[1] = 1'b1; sbr_req[2] = 1'b1;
        mgr_gnt = 1'b1;
        for (int c = 0; c < 3; c++) step();
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL rmid_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mgr_rready !== 1'b0) begin
            fails++;
            $display("FAIL rmid_empty: got busy=%b rready=%b expected 0/0", busy, mgr_rready);
        end
        sbr_req[1] = 1'b1; sbr_req[3] = 1'b1;
        mgr_gnt = 1'b1;
        #1;
        checks++;
        if (gnt_idx() != 1) begin
            fails++; $display("FAIL rmid_next_gnt: got %0d expected 1", gnt_idx());
        end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        sbr_req[0] = 1'b1;
        mgr_gnt    = 1'b1;
        step();
        step();
        mgr_rvalid = 1'b1;
        #1;
        checks++;
        if (sbr_gnt[0] !== 1'b1 || sbr_rvalid[0] !== 1'b1 || mgr_rready !== 1'b1) begin
            fails++;
            $display("FAIL pushpop: got gnt=%b rvalid=%b rready=%b expected 1/1/1",
                     sbr_gnt[0], sbr_rvalid[0], mgr_rready);
        end
        step();
        mgr_rvalid = 1'b0;
        // occupancy 2 leaves room for exactly two more grants
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (mgr_req !== (c < 2) || busy !== 1'b1) begin
                fails++;
                $display("FAIL pushpop_occ c%0d: got req=%b busy=%b expected %b/1",
                         c, mgr_req, busy, (c < 2));
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            sbr_addr[k]  = 32'h1000_0000 + (32'(k) << 8);
            sbr_we[k]    = k[0];
            sbr_be[k]    = 4'hF;
            sbr_wdata[k] = 32'hC0DE_0000 + 32'(k);
            sbr_aid[k]   = IW'(k + 1);
        end
        idle_inputs();
        #1;
        test_reset();
        test_lock();
        test_weighted();
        test_full_stall();
        test_routing();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
